// File: rtl/bk_pkg.sv
// Shared definitions for the Brent-Kung prefix datapaths.
// Holds the level-count helper and the per-bit generate/propagate pair type.
package bk_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } bk_gp_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bk_cells.sv
// Leaf prefix cells shared by the Brent-Kung adder/subtractor family.
// GP forms bit generate/propagate, Black merges groups, Gray merges generate only.
module GPCell (
    input  logic a,
    input  logic b,
    output logic g,
    output logic p
);
    assign g = a & b;
    assign p = a ^ b;
endmodule

module BlackCell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g,
    output logic p
);
    assign g = g_hi | (p_hi & g_lo);
    assign p = p_hi & p_lo;
endmodule

module GrayCell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    output logic g
);
    assign g = g_hi | (p_hi & g_lo);
endmodule

// File: rtl/bk_pipe_slice.sv
// One valid/ready register slice: loads when empty or when downstream drains.
// Data only loads with a valid beat so idle cycles never pull in junk.
module bk_pipe_slice #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end
endmodule

// File: rtl/brent_kung_sub_pipe.sv
// Three-stage Brent-Kung subtractor D = A - B - BIN, computed as A + ~B + ~BIN.
// Stage 1 forms bit P/G, stage 2 holds the up-sweep, stage 3 the down-sweep result.
module brent_kung_sub_pipe
    import bk_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] D,
    output logic             BORROW,
    output logic             OVF,
    output logic             ZERO
);
    localparam int LVL = clog2(WIDTH);
    localparam int S1W = 2 * WIDTH + 3;
    localparam int S2W = 3 * WIDTH + 3;
    localparam int S3W = WIDTH + 3;

    logic v1, v2, adv1, adv2, adv3;

    // ---------------- stage 1: bit generate / propagate
    logic [WIDTH-1:0] b_n, bit_p, bit_g;
    logic [S1W-1:0]   s1_d, s1_q;

    assign b_n = ~B;

    for (genvar i = 0; i < WIDTH; i++) begin : g_gp
        GPCell u_gp (
            .a(A[i]),
            .b(b_n[i]),
            .g(bit_g[i]),
            .p(bit_p[i])
        );
    end

    assign s1_d = {bit_p, bit_g, ~BIN, A[WIDTH-1], B[WIDTH-1]};

    bk_pipe_slice #(.DW(S1W)) u_s1 (
        .clk      (CLK),
        .rst_n    (RST_N),
        .in_valid (IN_VALID),
        .in_ready (adv1),
        .in_data  (s1_d),
        .out_valid(v1),
        .out_ready(adv2),
        .out_data (s1_q)
    );

    assign IN_READY = adv1;

    logic [WIDTH-1:0] s1_p, s1_g;
    logic             s1_c0, s1_am, s1_bm;

    assign {s1_p, s1_g, s1_c0, s1_am, s1_bm} = s1_q;

    // ---------------- stage 2: up-sweep, carry-in folded into bit 0
    bk_gp_t up [LVL+1][WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_lvl0
        if (i == 0) begin : g_cin
            logic g_f;
            GrayCell u_cin (
                .g_hi(s1_g[0]),
                .p_hi(s1_p[0]),
                .g_lo(s1_c0),
                .g   (g_f)
            );
            assign up[0][0] = '{g: g_f, p: s1_p[0]};
        end else begin : g_bit
            assign up[0][i] = '{g: s1_g[i], p: s1_p[i]};
        end
    end

    for (genvar l = 1; l <= LVL; l++) begin : g_up
        for (genvar i = 0; i < WIDTH; i++) begin : g_col
            if ((i + 1) % (1 << l) == 0) begin : g_blk
                logic gb, pb;
                BlackCell u_blk (
                    .g_hi(up[l-1][i].g),
                    .p_hi(up[l-1][i].p),
                    .g_lo(up[l-1][i-(1<<(l-1))].g),
                    .p_lo(up[l-1][i-(1<<(l-1))].p),
                    .g   (gb),
                    .p   (pb)
                );
                assign up[l][i] = '{g: gb, p: pb};
            end else begin : g_pass
                assign up[l][i] = up[l-1][i];
            end
        end
    end

    logic [WIDTH-1:0] up_g, up_p;
    logic [S2W-1:0]   s2_d, s2_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_upo
        assign up_g[i] = up[LVL][i].g;
        assign up_p[i] = up[LVL][i].p;
    end

    assign s2_d = {up_g, up_p, s1_p, s1_c0, s1_am, s1_bm};

    bk_pipe_slice #(.DW(S2W)) u_s2 (
        .clk      (CLK),
        .rst_n    (RST_N),
        .in_valid (v1),
        .in_ready (adv2),
        .in_data  (s2_d),
        .out_valid(v2),
        .out_ready(adv3),
        .out_data (s2_q)
    );

    logic [WIDTH-1:0] s2_g, s2_p, s2_bp;
    logic             s2_c0, s2_am, s2_bm;

    assign {s2_g, s2_p, s2_bp, s2_c0, s2_am, s2_bm} = s2_q;

    // full-prefix columns (2^k-1) need no group propagate downstream
    logic [LVL:0] unused_p_bits;

    for (genvar k = 0; k <= LVL; k++) begin : g_unp
        assign unused_p_bits[k] = s2_p[(1<<k)-1];
    end

    // ---------------- stage 3: down-sweep gray cells
    logic dn [1:LVL][WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_dtop
        assign dn[LVL][i] = s2_g[i];
    end

    for (genvar l = LVL - 1; l >= 1; l--) begin : g_dn
        for (genvar i = 0; i < WIDTH; i++) begin : g_col
            if (((i + 1) % (1 << l) == (1 << (l - 1))) && (i >= (1 << l))) begin : g_gry
                logic gg;
                GrayCell u_gry (
                    .g_hi(dn[l+1][i]),
                    .p_hi(s2_p[i]),
                    .g_lo(dn[l+1][i-(1<<(l-1))]),
                    .g   (gg)
                );
                assign dn[l][i] = gg;
            end else begin : g_pass
                assign dn[l][i] = dn[l+1][i];
            end
        end
    end

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] diff;
    logic             brw, ovf, zro;
    logic [S3W-1:0]   s3_d, s3_q;

    assign c[0] = s2_c0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cy
        assign c[i+1] = dn[1][i];
    end

    assign diff = s2_bp ^ c[WIDTH-1:0];
    assign brw  = ~c[WIDTH];
    assign ovf  = (s2_am ^ s2_bm) & (diff[WIDTH-1] ^ s2_am);
    assign zro  = ~|diff;
    assign s3_d = {diff, brw, ovf, zro};

    bk_pipe_slice #(.DW(S3W)) u_s3 (
        .clk      (CLK),
        .rst_n    (RST_N),
        .in_valid (v2),
        .in_ready (adv3),
        .in_data  (s3_d),
        .out_valid(OUT_VALID),
        .out_ready(OUT_READY),
        .out_data (s3_q)
    );

    assign {D, BORROW, OVF, ZERO} = s3_q;
endmodule

// File: tb/tb_brent_kung_sub_pipe.sv
// Directed and random checks of the pipelined Brent-Kung subtractor.
// Two instances (16 and 32 bit) share stimulus and handshake inputs.
module tb_brent_kung_sub_pipe;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready, bin;
    logic [31:0] a, b;

    logic        rdy16, ov16, br16, of16, z16;
    logic [15:0] d16;
    logic        rdy32, ov32, br32, of32, z32;
    logic [31:0] d32;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    brent_kung_sub_pipe #(.WIDTH(16)) dut16 (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(rdy16),
        .A(a[15:0]), .B(b[15:0]), .BIN(bin), .OUT_VALID(ov16),
        .OUT_READY(out_ready), .D(d16), .BORROW(br16), .OVF(of16), .ZERO(z16)
    );

    brent_kung_sub_pipe #(.WIDTH(32)) dut32 (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(rdy32),
        .A(a), .B(b), .BIN(bin), .OUT_VALID(ov32),
        .OUT_READY(out_ready), .D(d32), .BORROW(br32), .OVF(of32), .ZERO(z32)
    );

    wire [34:0] obs16 = {of16, z16, br16, 16'h0, d16};
    wire [34:0] obs32 = {of32, z32, br32, d32};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {OVF, ZERO, BORROW, D} for a w-bit subtract
    function automatic logic [34:0] ref_sub(input logic [31:0] x, input logic [31:0] y,
                                            input logic bi, input int w);
        logic [31:0] m, dd;
        logic [32:0] t;
        logic        of;
        m  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        t  = {1'b0, x & m} - {1'b0, y & m} - {32'd0, bi};
        dd = t[31:0] & m;
        of = (x[w-1] != y[w-1]) && (dd[w-1] != x[w-1]);
        return {of, (dd == 32'd0), t[w], dd};
    endfunction

    task automatic single(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic bi, input logic [15:0] ed, input logic eb,
                          input logic eo, input logic ez);
        int lat;
        lat = 0;
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        a = {16'h0, x}; b = {16'h0, y}; bin = bi;
        #1;
        check({tag, "_rdy"}, rdy16, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (ov16) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, lat, 3);
        check({tag, "_d"}, d16, ed);
        check({tag, "_flags"}, {br16, of16, z16}, {eb, eo, ez});
    endtask

    logic [34:0] q16[$];
    logic [34:0] q32[$];

    initial begin
        int sent, got, stale;
        logic [34:0] e;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; bin = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out", {ov16, obs16}, 36'h0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst_in_ready", rdy16, 1'b1);

        single("basic", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
        single("wrap",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        single("zero",  16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        single("ovf_n", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        single("ovf_p", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
        @(negedge clk);

        // backpressure: 10 back-to-back operands, consumer stalled for 6 cycles
        sent = 0; got = 0; q16.delete();
        for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 6);
            in_valid  = (sent < 10);
            a = {16'h0, 16'h0100 * sent[15:0] + 16'h0007};
            b = {16'h0, 16'h0003 * sent[15:0]};
            bin = sent[0];
            #1;
            if (cyc == 3 || cyc == 5) begin
                check("bp_hold", {ov16, obs16}, {1'b1, ref_sub(32'h0007, 32'h0, 1'b0, 16)});
            end
            if (cyc == 5) begin
                check("bp_accepts", sent, 3);
                check("bp_in_ready", rdy16, 1'b0);
            end
            if (in_valid && rdy16) begin
                q16.push_back(ref_sub(a, b, bin, 16));
                sent++;
            end
            if (ov16 && out_ready) begin
                if (q16.size() == 0) begin
                    check("bp_extra", 1'b1, 1'b0);
                end else begin
                    e = q16.pop_front();
                    check("bp_data", obs16, e);
                end
                got++;
            end
        end
        check("bp_count", got, 10);
        in_valid = 1'b0;

        // reset with two results in flight, one already at the output
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        a = 32'h0000_0009; b = 32'h0000_0001; bin = 1'b0;
        @(negedge clk);
        a = 32'h0000_0004;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("mr_pre_valid", ov16, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("mr_async", {ov16, obs16}, 36'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (ov16) stale++;
        end
        check("mr_no_stale", stale, 0);

        // random traffic on both widths
        sent = 0; q16.delete(); q32.delete();
        for (int cyc = 0; cyc < 12000; cyc++) begin
            @(negedge clk);
            in_valid  = (sent < 3000) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = $urandom; b = $urandom; bin = 1'($urandom);
            #1;
            if (in_valid && rdy16) begin
                q16.push_back(ref_sub(a, b, bin, 16));
                sent++;
            end
            if (in_valid && rdy32) q32.push_back(ref_sub(a, b, bin, 32));
            if (ov16 && out_ready) begin
                if (q16.size() == 0) check("rnd16_extra", 1'b1, 1'b0);
                else begin
                    e = q16.pop_front();
                    check("rnd16", obs16, e);
                end
            end
            if (ov32 && out_ready) begin
                if (q32.size() == 0) check("rnd32_extra", 1'b1, 1'b0);
                else begin
                    e = q32.pop_front();
                    check("rnd32", obs32, e);
                end
            end
            if (sent >= 3000 && q16.size() == 0 && q32.size() == 0) break;
        end
        check("rnd_sent", sent, 3000);
        check("rnd16_left", q16.size(), 0);
        check("rnd32_left", q32.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
